fetch_unit: RTL
===============

# fetch_unit

Program-counter and fetch-sequencing block for the 9-bit-instruction core. It consumes the `Jump` and `BranchEn` strobes produced by the control decoder, together with the ALU condition flag, and advances, redirects, holds or halts the program counter that addresses instruction ROM. It holds a small loadable branch-target lookup table, a run/halt state machine and a saturating retired-instruction counter for the test harness.

## Interface
- `PC_W`, 10 — program-counter width; ROM depth is 2^PC_W.
- `LUT_N`, 16 — branch-target LUT entries; index width is log2(LUT_N).
- `START_ADDR`, 0 — PC value loaded on `Start`.
- `Clk` input 1 — single clock; all state updates on its rising edge.
- `Reset` input 1 — synchronous, active-high.
- `Start` input 1 — begin or restart execution; sampled in IDLE and DONE.
- `Halt` input 1 — stop request (decoded halt instruction).
- `Jump` input 1 — unconditional redirect strobe from the control decoder.
- `BranchEn` input 1 — conditional redirect strobe from the control decoder.
- `CondFlag` input 1 — ALU condition flag; qualifies `BranchEn`.
- `TargetIdx` input log2(LUT_N) — LUT index taken from instruction bits.
- `LutWe` input 1 — LUT write enable.
- `LutAddr` input log2(LUT_N) — LUT write index.
- `LutData` input PC_W — LUT write data (absolute target address).
- `ProgCtr` output PC_W — current instruction address to ROM.
- `Running` output 1 — high in RUN.
- `Done` output 1 — high in DONE.
- `RetireCnt` output 16 — instructions retired since last `Start`; saturates.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `Start`.
  - RUN → DONE on `Halt`.
  - DONE → RUN on `Start`.
  - No other transitions.
- Entry into RUN (from IDLE or DONE): `ProgCtr` ← `START_ADDR`; `RetireCnt` ← 0.
- In RUN, one instruction retires per cycle. Next-PC priority, highest first:
  - `Halt`: PC holds, go to DONE; the halting instruction is not counted.
  - `Jump`: PC ← LUT[`TargetIdx`].
  - `BranchEn` && `CondFlag`: PC ← LUT[`TargetIdx`].
  - Otherwise: PC ← PC+1, modulo 2^PC_W; wrap from all-ones to 0 is silent.
- `BranchEn` with `CondFlag`=0 falls through to PC+1.
- `RetireCnt` increments on every non-halt RUN cycle and saturates at 0xFFFF.
- In IDLE and DONE, PC and `RetireCnt` hold, and `Jump`, `BranchEn` and `Halt` are ignored.
- `Start` in RUN is ignored.
- LUT writes are accepted in any state.
  - Write and redirect to the same index in one cycle: the redirect uses the old entry; the new entry is visible from the next cycle.
- Reset values:
  - State IDLE.
  - `ProgCtr`=0, `Running`=0, `Done`=0, `RetireCnt`=0.
  - All LUT entries 0.
- `Reset` overrides every other input, including mid-RUN and mid-LUT-write; that write is discarded.

## Timing
- All outputs are registered; none depend combinationally on inputs.
- Redirect latency is 1 cycle: the strobe sampled at edge N gives the target on `ProgCtr` after edge N.
- `Start` sampled at edge N: `Running`=1 and `ProgCtr`=`START_ADDR` after edge N.
- `Halt` sampled at edge N: `Done`=1 after edge N, and `ProgCtr` keeps the halting instruction's address.
- LUT read is combinational inside the block; the write lands at the edge.

## Test plan
- Reset, then `Start` with `START_ADDR`=0, 5 plain cycles → `ProgCtr` 0,1,2,3,4,5; `RetireCnt`=5; `Running`=1.
- Write LUT[3]=0x120; at PC=2 drive `BranchEn`=1: `CondFlag`=0 → PC 3; then `CondFlag`=1 with `TargetIdx`=3 → PC 0x120.
- Same cycle `Jump`=1, `Halt`=1 at PC=7 → PC stays 7, `Done`=1, `RetireCnt` unchanged; a later `Start` → PC 0, `RetireCnt` 0.
- Same cycle LUT[1]←0x040 (old 0x010) and `Jump` with `TargetIdx`=1 → PC 0x010; a repeat jump next cycle → PC 0x040.
- PC=0x3FF with no redirect → PC 0x000, `Running` stays 1; `RetireCnt` forced to 0xFFFF stays at 0xFFFF.
- `Reset` mid-RUN at PC=0x055 → next cycle PC 0, IDLE, all LUT entries read 0; `Jump` in IDLE → PC stays 0.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, branch-target LUT and run/halt sequencing for the 9-bit core
module fetch_unit #(
  parameter int unsigned          PC_W       = 10,
  parameter int unsigned          LUT_N      = 16,
  parameter logic [PC_W-1:0]      START_ADDR = '0,
  localparam int unsigned         IDX_W      = $clog2(LUT_N)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Jump,
  input  logic             BranchEn,
  input  logic             CondFlag,
  input  logic [IDX_W-1:0] TargetIdx,
  input  logic             LutWe,
  input  logic [IDX_W-1:0] LutAddr,
  input  logic [PC_W-1:0]  LutData,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [15:0]      RetireCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] lut [LUT_N];
  logic [PC_W-1:0] pc_next;
  logic            redirect;
  logic            launch;
  logic            retire;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: if (Start) begin
        state_next = RUN;
        launch     = 1'b1;
      end
      RUN: begin
        if (Halt) state_next = DONE;
        else      retire     = 1'b1;
      end
      DONE: if (Start) begin
        state_next = RUN;
        launch     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // The LUT read happens before the edge, so a same-cycle write is not seen by the redirect.
  assign redirect = Jump | (BranchEn & CondFlag);
  assign pc_next  = redirect ? lut[TargetIdx] : ProgCtr + PC_W'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ProgCtr   <= '0;
      RetireCnt <= '0;
    end else if (launch) begin
      ProgCtr   <= START_ADDR;
      RetireCnt <= '0;
    end else if (retire) begin
      ProgCtr <= pc_next;
      if (RetireCnt != 16'hFFFF) RetireCnt <= RetireCnt + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

  assign Running = (state == RUN);
  assign Done    = (state == DONE);

endmodule
